de0_nano_sopc_led_arbiter: RTL

Two-port arbiter that shares the single Avalon-MM slave of the 8-bit LED PIO register between two requesters, e.g. the Nios II data master path and a hardware pattern engine. It serialises accesses, drives the PIO slave's `address`, `chipselect`, `write_n` and `writedata` pins directly, and returns the sampled `readdata` to the granted requester. It sits between the requesters and the PIO instance inside the SOPC top level.

---
 rtl/de0_nano_sopc_led_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/de0_nano_sopc_led_arbiter.sv
// de0_nano_sopc_led_arbiter
// Shares the single Avalon-MM slave of the 8-bit LED PIO between two
// requesters. Each access takes IDLE -> ACCESS -> ACK, so there is at most
// one access every three cycles. All PIO-side outputs are registered.
//
// Optional feature macro: LED_ARB_ROUND_ROBIN_EN
//   defined   : ties go to the requester that was not granted last
//   undefined : fixed priority, requester 0 always wins ties
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req*/wr*/addr*/wdata* requester side, held stable until the matching ack
//   ack*                  one-cycle completion pulse
//   rdata*                read data, held until the next read on that port
//   busy                  high whenever the FSM is not in IDLE
//   pio_*                 Avalon-MM pins of the PIO slave
//
// state  | meaning
// IDLE   | no access in flight, sampling requests
// ACCESS | chipselect asserted for one cycle, read data captured at its end
// ACK    | ack pulse to the granted port, bus released
module de0_nano_sopc_led_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  logic   grant;
  logic   wr_q;
  logic   winner;

`ifdef LED_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ~last_grant;
    else              winner = req1;
  end
`else
  // Port 0 wins every tie; port 1 only wins when it is alone.
  always_comb begin
    winner = 1'b0;
    winner = req1 & ~req0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      wr_q           <= 1'b0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      busy           <= 1'b0;
      pio_address    <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
`ifdef LED_ARB_ROUND_ROBIN_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            state          <= ACCESS;
            busy           <= 1'b1;
            grant          <= winner;
            wr_q           <= winner ? wr1 : wr0;
            pio_address    <= winner ? addr1 : addr0;
            pio_writedata  <= winner ? wdata1 : wdata0;
            pio_chipselect <= 1'b1;
            pio_write_n    <= winner ? ~wr1 : ~wr0;
          end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
          end
        end
        ACCESS: begin
          state          <= ACK;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          ack0           <= ~grant;
          ack1           <= grant;
          // PIO readdata is combinational from address, which has been
          // stable for the whole ACCESS cycle.
          if (!wr_q) begin
            if (grant) rdata1 <= pio_readdata;
            else       rdata0 <= pio_readdata;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
`ifdef LED_ARB_ROUND_ROBIN_EN
          last_grant <= grant;
`endif
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          ack0           <= 1'b0;
          ack1           <= 1'b0;
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule
